uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-aware round-robin arbiter in front of a byte-wide UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_PKT     = 64,
  parameter int GAP_TIMEOUT = 50_000,
  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [IW-1:0]        grant_id,
  output logic                 pkt_done,
  output logic                 pkt_abort
);

  localparam int CW  = $clog2(MAX_PKT + 1);
  localparam int GW  = $clog2(GAP_TIMEOUT + 1);
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        pick_id;
  logic [IW-1:0]        next_ptr;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;
  logic [CW-1:0]        byte_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 last_q;
  logic [NUM_REQ-1:0]   gsel;
  logic [NUM_REQ-1:0]   rot;
  logic [2*NUM_REQ-1:0] dbl;
  logic                 g_valid;
  logic                 g_last;
  logic [7:0]           g_data;
  logic                 accept;
  logic                 gap_expire;
  logic                 pkt_end;
  logic                 release_ok;

  // Rotate the request vector so the search always starts at rr_ptr.
  always_comb begin
    dbl = {req_valid, req_valid};
    rot = NUM_REQ'(dbl >> rr_ptr);
    off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IW'(j);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= IW1'(NUM_REQ)) sum = sum - IW1'(NUM_REQ);
    pick_id = sum[IW-1:0];
  end

  always_comb begin
    gsel    = NUM_REQ'(1) << grant_id;
    g_valid = |(req_valid & gsel);
    g_last  = |(req_last & gsel);
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) g_data = req_data[8*i +: 8];
    end
    next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|req_valid) state_nxt = SEND;
      SEND:      if (accept) state_nxt = WAIT_BUSY;
                 else if (gap_expire) state_nxt = IDLE;
      // Busy is only meaningful once the serializer has seen the start pulse.
      WAIT_BUSY: if (tx_busy && !tx_start) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = pkt_end ? IDLE : SEND;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == SEND && !tx_busy) ? gsel : '0;
    accept     = (state == SEND) && !tx_busy && g_valid;
    gap_expire = (state == SEND) && !g_valid && (gap_cnt == GW'(GAP_TIMEOUT - 1));
    pkt_end    = last_q || (byte_cnt == CW'(MAX_PKT));
    release_ok = (state == WAIT_DONE) && !tx_busy && pkt_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data      <= '0;
      tx_start     <= 1'b0;
      grant_active <= 1'b0;
      grant_id     <= '0;
      pkt_done     <= 1'b0;
      pkt_abort    <= 1'b0;
      rr_ptr       <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      last_q       <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id     <= pick_id;
            grant_active <= 1'b1;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            last_q       <= 1'b0;
          end
        end
        SEND: begin
          if (accept) begin
            tx_data  <= g_data;
            tx_start <= 1'b1;
            last_q   <= g_last;
            gap_cnt  <= '0;
            if (byte_cnt != CW'(MAX_PKT)) byte_cnt <= byte_cnt + CW'(1);
          end else if (gap_expire) begin
            pkt_abort    <= 1'b1;
            grant_active <= 1'b0;
            rr_ptr       <= next_ptr;
          end else if (!g_valid) begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        WAIT_DONE: begin
          // A last byte landing exactly on MAX_PKT still yields a single pkt_done.
          if (release_ok) begin
            pkt_done     <= 1'b1;
            grant_active <= 1'b0;
            rr_ptr       <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
